// File: rtl/uart_pkg.sv
// Shared UART definitions: TX controller state encoding, line levels
// and the baud divisor helper used by both TX and RX controllers.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    START,
    DATA,
    STOP
  } tx_state_e;

  localparam logic UART_IDLE_LEVEL  = 1'b1;
  localparam logic UART_START_LEVEL = 1'b0;

  function automatic int baud_divisor(input int clk_hz, input int baud);
    return clk_hz / baud;
  endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// Bit-period counter: counts 0..Divisor-1 and strobes tick_o on the terminal
// count. clr_i restarts the period so a bit can be aligned to an event.
module uart_baud_gen #(
  parameter int Divisor = 434
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clr_i,
  output logic tick_o
);

  localparam int CntW = (Divisor > 1) ? $clog2(Divisor) : 1;
  localparam logic [CntW-1:0] LastCnt = CntW'(Divisor - 1);

  logic [CntW-1:0] cnt_reg;
  logic [CntW-1:0] cnt_next;

  assign tick_o = (cnt_reg == LastCnt);

  always_comb begin
    cnt_next = cnt_reg + 1'b1;
    if (clr_i || tick_o) begin
      cnt_next = '0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_reg <= '0;
    end else begin
      cnt_reg <= cnt_next;
    end
  end

endmodule

// File: rtl/uart_tx_ctrl.sv
// UART transmit controller: pops one byte at a time from the TX FIFO and
// serialises it as start / LSB-first data / stop bits on a registered tx_o.
module uart_tx_ctrl
  import uart_pkg::*;
#(
  parameter int ClkFreqHz = 50_000_000,
  parameter int BaudRate  = 115_200,
  parameter int DataBits  = 8,
  parameter int StopBits  = 1
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                en_i,
  input  logic                fifo_empty_i,
  output logic                fifo_rd_en_o,
  input  logic [DataBits-1:0] fifo_rd_data_i,
  output logic                tx_o,
  output logic                busy_o,
  output logic                done_o
);

  localparam int Divisor = baud_divisor(ClkFreqHz, BaudRate);
  localparam int BitW    = $clog2(DataBits + 1);
  localparam logic [BitW-1:0] LastDataBit = BitW'(DataBits - 1);
  localparam logic [BitW-1:0] LastStopBit = BitW'(StopBits - 1);

  if (Divisor < 2) begin : g_bad_divisor
    $error("uart_tx_ctrl: baud divisor must be at least 2");
  end
  if (DataBits < 5 || DataBits > 9) begin : g_bad_data_bits
    $error("uart_tx_ctrl: DataBits must be within 5..9");
  end
  if (StopBits < 1 || StopBits > 2) begin : g_bad_stop_bits
    $error("uart_tx_ctrl: StopBits must be 1 or 2");
  end

  tx_state_e           state_reg, state_next;
  logic [DataBits-1:0] shift_reg, shift_next;
  logic [BitW-1:0]     bit_cnt_reg, bit_cnt_next;
  logic                tx_reg, tx_next;
  logic                rd_req;
  logic                baud_clr;
  logic                baud_tick;

  uart_baud_gen #(
    .Divisor(Divisor)
  ) u_baud_gen (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .clr_i (baud_clr),
    .tick_o(baud_tick)
  );

  // A pop is never issued while reset is held, so an aborted frame does not
  // cost the FIFO a second byte.
  assign rd_req = en_i & ~fifo_empty_i & ~rst_i;

  always_comb begin
    state_next   = state_reg;
    shift_next   = shift_reg;
    bit_cnt_next = bit_cnt_reg;
    baud_clr     = 1'b0;
    fifo_rd_en_o = 1'b0;
    done_o       = 1'b0;
    case (state_reg)
      IDLE: begin
        fifo_rd_en_o = rd_req;
        if (rd_req) begin
          state_next = FETCH;
        end
      end
      FETCH: begin
        shift_next   = fifo_rd_data_i;
        bit_cnt_next = '0;
        baud_clr     = 1'b1;
        state_next   = START;
      end
      START: begin
        if (baud_tick) begin
          state_next = DATA;
        end
      end
      DATA: begin
        if (baud_tick) begin
          shift_next = shift_reg >> 1;
          if (bit_cnt_reg == LastDataBit) begin
            bit_cnt_next = '0;
            state_next   = STOP;
          end else begin
            bit_cnt_next = bit_cnt_reg + 1'b1;
          end
        end
      end
      STOP: begin
        if (baud_tick) begin
          if (bit_cnt_reg == LastStopBit) begin
            bit_cnt_next = '0;
            done_o       = 1'b1;
            state_next   = IDLE;
          end else begin
            bit_cnt_next = bit_cnt_reg + 1'b1;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Line level is derived from the upcoming state so tx_o can be a flop.
  always_comb begin
    tx_next = UART_IDLE_LEVEL;
    case (state_next)
      START:   tx_next = UART_START_LEVEL;
      DATA:    tx_next = shift_next[0];
      default: tx_next = UART_IDLE_LEVEL;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_reg   <= IDLE;
      shift_reg   <= '0;
      bit_cnt_reg <= '0;
      tx_reg      <= UART_IDLE_LEVEL;
    end else begin
      state_reg   <= state_next;
      shift_reg   <= shift_next;
      bit_cnt_reg <= bit_cnt_next;
      tx_reg      <= tx_next;
    end
  end

  assign tx_o   = tx_reg;
  assign busy_o = (state_reg != IDLE);

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// Bench for uart_tx_ctrl with a 4-deep registered-read FIFO and a mid-bit
// line sampler that decodes frames and compares them to the push order.
module tb_uart_tx_ctrl;

  localparam int DIV   = 4;
  localparam int FRAME = (1 + 8 + 1) * DIV;

  logic       clk = 1'b0;
  logic       rst_i = 1'b1;
  logic       en_i = 1'b0;
  logic       fifo_empty;
  logic       fifo_rd_en;
  logic [7:0] fifo_rd_data = 8'h00;
  logic       tx_o;
  logic       busy_o;
  logic       done_o;

  always #5 clk = ~clk;

  uart_tx_ctrl #(
    .ClkFreqHz(16),
    .BaudRate (4),
    .DataBits (8),
    .StopBits (1)
  ) dut (
    .clk_i         (clk),
    .rst_i         (rst_i),
    .en_i          (en_i),
    .fifo_empty_i  (fifo_empty),
    .fifo_rd_en_o  (fifo_rd_en),
    .fifo_rd_data_i(fifo_rd_data),
    .tx_o          (tx_o),
    .busy_o        (busy_o),
    .done_o        (done_o)
  );

  // TX FIFO, depth 4, read data registered (valid the cycle after a pop)
  logic       push_en = 1'b0;
  logic [7:0] push_data = 8'h00;
  logic [7:0] fmem [4];
  logic [1:0] wp = 2'd0;
  logic [1:0] rp = 2'd0;
  logic [2:0] fcnt = 3'd0;
  logic       f_wr, f_rd;

  assign f_wr       = push_en && (fcnt != 3'd4);
  assign f_rd       = fifo_rd_en && (fcnt != 3'd0);
  assign fifo_empty = (fcnt == 3'd0);

  always @(posedge clk) begin
    if (f_wr) begin
      fmem[wp] <= push_data;
      wp       <= wp + 2'd1;
    end
    if (f_rd) begin
      fifo_rd_data <= fmem[rp];
      rp           <= rp + 2'd1;
    end
    if (f_wr && !f_rd) fcnt <= fcnt + 3'd1;
    else if (f_rd && !f_wr) fcnt <= fcnt - 3'd1;
  end

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference: bytes in push order, consumed by decoded frames
  logic [7:0] exp_q [$];
  logic [7:0] frame_data [$];
  int         frame_gap [$];

  int         cyc = 0;
  int         pops = 0;
  int         last_pop_cyc = -100;
  int         frames_done = 0;
  int         aborts = 0;
  bit         in_frame = 0;
  int         fcyc = 0;
  int         idle_cnt = 0;
  int         cur_gap = 0;
  int         done_cnt = 0;
  int         done_at = 0;
  bit         busy_all = 0;
  logic [9:0] smp = '0;

  always begin : line_monitor
    @(negedge clk);
    #1;
    cyc++;
    if (fifo_rd_en) begin
      pops++;
      last_pop_cyc = cyc;
      check("pop_nonempty", fifo_empty, 1'b0);
    end
    if (rst_i) begin
      if (in_frame) begin
        in_frame = 0;
        aborts++;
        if (exp_q.size() > 0) void'(exp_q.pop_front());
      end
      idle_cnt = 0;
    end else if (!in_frame) begin
      if (done_o) check("done_idle", done_o, 1'b0);
      if (tx_o == 1'b0) begin
        in_frame = 1;
        fcyc     = 0;
        cur_gap  = idle_cnt;
        done_cnt = 0;
        done_at  = 0;
        busy_all = 1;
        smp      = '0;
        check("pop_to_start", cyc - last_pop_cyc, 2);
      end else begin
        idle_cnt++;
      end
    end
    if (in_frame && !rst_i) begin
      fcyc++;
      if (!busy_o) busy_all = 0;
      if (done_o) begin
        done_cnt++;
        done_at = fcyc;
      end
      if (fcyc % DIV == 2) smp[(fcyc - 2) / DIV] = tx_o;
      if (fcyc == FRAME) begin
        check("start_bit", smp[0], 1'b0);
        check("stop_bit", smp[9], 1'b1);
        check("done_count", done_cnt, 1);
        check("done_cycle", done_at, FRAME);
        check("busy_frame", busy_all, 1'b1);
        if (exp_q.size() == 0) begin
          check("exp_avail", exp_q.size(), 1);
        end else begin
          check("frame_data", smp[8:1], exp_q.pop_front());
        end
        frame_data.push_back(smp[8:1]);
        frame_gap.push_back(cur_gap);
        frames_done++;
        in_frame = 0;
        idle_cnt = 0;
      end
    end
  end

  task automatic push_byte(input logic [7:0] b);
    int guard = 0;
    while (fcnt == 3'd4 && guard < 2000) begin
      @(negedge clk);
      guard++;
    end
    check("push_room", guard < 2000, 1'b1);
    push_en   = 1'b1;
    push_data = b;
    exp_q.push_back(b);
    @(negedge clk);
    push_en = 1'b0;
  endtask

  task automatic wait_frames(input int n);
    int guard = 0;
    while (frames_done < n && guard < 3000) begin
      @(negedge clk);
      guard++;
    end
    check("wait_frames", frames_done, n);
  endtask

  task automatic wait_fcyc_at_least(input int c, input string tag);
    int guard = 0;
    while (!(in_frame && fcyc >= c) && guard < 500) begin
      @(negedge clk);
      guard++;
    end
    check(tag, in_frame && fcyc >= c, 1'b1);
  endtask

  initial begin
    int         p0, f0, a0;
    bit         any_low, any_busy;
    logic [7:0] rb [16];

    repeat (3) @(negedge clk);
    rst_i = 1'b0;
    @(negedge clk);
    #2;
    check("rst_tx", tx_o, 1'b1);
    check("rst_busy", busy_o, 1'b0);
    check("rst_rd_en", fifo_rd_en, 1'b0);
    check("rst_done", done_o, 1'b0);

    // 1: enabled with an empty FIFO stays idle
    en_i = 1'b1;
    p0 = pops;
    any_low = 0;
    any_busy = 0;
    repeat (100) begin
      @(negedge clk);
      #2;
      if (!tx_o) any_low = 1;
      if (busy_o) any_busy = 1;
    end
    check("t1_pops", pops - p0, 0);
    check("t1_tx_low", any_low, 1'b0);
    check("t1_busy", any_busy, 1'b0);
    @(negedge clk);
    $display("t1 idle with empty FIFO: pops=%0d", pops - p0);

    // 2: single frame 8'hA5
    p0 = pops;
    f0 = frames_done;
    push_byte(8'hA5);
    wait_frames(f0 + 1);
    check("t2_data", frame_data[f0], 8'hA5);
    check("t2_pops", pops - p0, 1);
    $display("t2 frame data=%02h", frame_data[f0]);

    // 3: three back-to-back frames
    p0 = pops;
    f0 = frames_done;
    push_byte(8'h00);
    push_byte(8'hFF);
    push_byte(8'h3C);
    wait_frames(f0 + 3);
    check("t3_data0", frame_data[f0], 8'h00);
    check("t3_data1", frame_data[f0 + 1], 8'hFF);
    check("t3_data2", frame_data[f0 + 2], 8'h3C);
    check("t3_gap1", frame_gap[f0 + 1], 2);
    check("t3_gap2", frame_gap[f0 + 2], 2);
    check("t3_pops", pops - p0, 3);
    repeat (3) @(negedge clk);
    check("t3_empty", fifo_empty, 1'b1);
    check("t3_busy", busy_o, 1'b0);
    $display("t3 frames %02h %02h %02h gaps %0d %0d", frame_data[f0], frame_data[f0 + 1],
             frame_data[f0 + 2], frame_gap[f0 + 1], frame_gap[f0 + 2]);

    // 4: en_i dropped during data bits
    p0 = pops;
    f0 = frames_done;
    push_byte(8'h55);
    push_byte(8'h0F);
    wait_fcyc_at_least(10, "t4_reach_data");
    en_i = 1'b0;
    wait_frames(f0 + 1);
    repeat (20) @(negedge clk);
    check("t4_pops_held", pops - p0, 1);
    check("t4_fifo_left", fcnt, 3'd1);
    check("t4_busy", busy_o, 1'b0);
    en_i = 1'b1;
    wait_frames(f0 + 2);
    check("t4_data0", frame_data[f0], 8'h55);
    check("t4_data1", frame_data[f0 + 1], 8'h0F);
    $display("t4 frames %02h %02h", frame_data[f0], frame_data[f0 + 1]);

    // 5: reset during data bit 3
    a0 = aborts;
    push_byte(8'hC3);
    push_byte(8'h12);
    push_byte(8'h34);
    wait_fcyc_at_least(18, "t5_reach_bit3");
    rst_i = 1'b1;
    @(posedge clk);
    #1;
    check("t5_tx_after_rst", tx_o, 1'b1);
    check("t5_busy_after_rst", busy_o, 1'b0);
    p0 = pops;
    repeat (5) @(negedge clk);
    check("t5_no_pop_in_rst", pops - p0, 0);
    rst_i = 1'b0;
    f0 = frames_done;
    wait_frames(f0 + 2);
    check("t5_aborts", aborts - a0, 1);
    check("t5_data0", frame_data[f0], 8'h12);
    check("t5_data1", frame_data[f0 + 1], 8'h34);
    $display("t5 after reset frames %02h %02h", frame_data[f0], frame_data[f0 + 1]);

    // 6: random bytes through the sampler
    f0 = frames_done;
    for (int i = 0; i < 16; i++) begin
      rb[i] = 8'($urandom_range(0, 255));
      push_byte(rb[i]);
    end
    wait_frames(f0 + 16);
    for (int i = 0; i < 16; i++) begin
      check("t6_data", frame_data[f0 + i], rb[i]);
      $display("t6 frame %0d data=%02h", i, frame_data[f0 + i]);
    end
    repeat (4) @(negedge clk);
    check("t6_exp_drained", exp_q.size(), 0);
    check("t6_empty", fifo_empty, 1'b1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
